// File: rtl/k_nearest_sorter.sv
`default_nettype none
// ============================================================================
// Module      : k_nearest_sorter
// Description : Streaming top-K selector. Accepts one (distance, type) sample
//               per cycle and keeps the K smallest distances in a sorted
//               register list (slot 0 nearest). At end of stream it pulses
//               valid_sort; the packed list then holds until the next start.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               start             - begin a new query (taken only in IDLE)
//               sample_valid/ready, sample_dist/type/last - sample handshake
//               valid_sort        - one-cycle pulse, list is final
//               k_nearest_neighbours_type / k_nearest_dist - packed slots,
//                                   slot i at [(i+1)*W-1 -: W]
//               n_valid           - occupied slots, saturates at K
//               busy              - FSM not in IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module k_nearest_sorter #(
  parameter int K      = 4,
  parameter int TYPE_W = 2,
  parameter int DIST_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  input  logic [DIST_W-1:0]       sample_dist,
  input  logic [TYPE_W-1:0]       sample_type,
  input  logic                    sample_last,
  output logic                    valid_sort,
  output logic [TYPE_W*K-1:0]     k_nearest_neighbours_type,
  output logic [DIST_W*K-1:0]     k_nearest_dist,
  output logic [$clog2(K+1)-1:0]  n_valid,
  output logic                    busy
);

  localparam int NW = $clog2(K+1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_EMIT    = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [DIST_W-1:0] dist_q [K];
  logic [TYPE_W-1:0] type_q [K];
  logic [K-1:0]      occ_q;
  logic [NW-1:0]     cnt_q;

  logic [DIST_W-1:0] dist_n [K];
  logic [TYPE_W-1:0] type_n [K];
  logic [K-1:0]      occ_n;

  logic              accept;
  logic              clear;
  logic [K-1:0]      lt;        // sample belongs at or above slot i
  logic [K-1:0]      lt_prev;   // sample belongs strictly above slot i
  logic [DIST_W-1:0] up_dist [K];
  logic [TYPE_W-1:0] up_type [K];
  logic [K-1:0]      up_occ;

  assign accept = (state == S_COLLECT) && sample_valid;
  assign clear  = (state == S_IDLE) && start;

  // The list is kept sorted with occupied slots first, so lt is monotonic:
  // once true at slot i it is true for every higher slot. The insert point
  // is the first slot where lt rises; every slot beyond it takes its
  // upper neighbour's contents.
  generate
    for (genvar i = 0; i < K; i++) begin : g_slot
      assign lt[i] = !occ_q[i] || (sample_dist < dist_q[i]);
      if (i == 0) begin : g_head
        assign lt_prev[i] = 1'b0;
        assign up_dist[i] = sample_dist;
        assign up_type[i] = sample_type;
        assign up_occ[i]  = 1'b1;
      end else begin : g_tail
        assign lt_prev[i] = lt[i-1];
        assign up_dist[i] = dist_q[i-1];
        assign up_type[i] = type_q[i-1];
        assign up_occ[i]  = occ_q[i-1];
      end
      assign k_nearest_neighbours_type[(i+1)*TYPE_W-1 -: TYPE_W] = type_q[i];
      assign k_nearest_dist[(i+1)*DIST_W-1 -: DIST_W]            = dist_q[i];
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < K; i++) begin
      dist_n[i] = dist_q[i];
      type_n[i] = type_q[i];
      occ_n[i]  = occ_q[i];
      if (lt[i]) begin
        if (lt_prev[i]) begin
          dist_n[i] = up_dist[i];
          type_n[i] = up_type[i];
          occ_n[i]  = up_occ[i];
        end else begin
          dist_n[i] = sample_dist;
          type_n[i] = sample_type;
          occ_n[i]  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < K; i++) begin
        dist_q[i] <= '1;
        type_q[i] <= '0;
      end
      occ_q <= '0;
      cnt_q <= '0;
    end else if (accept) begin
      for (int i = 0; i < K; i++) begin
        dist_q[i] <= dist_n[i];
        type_q[i] <= type_n[i];
      end
      occ_q <= occ_n;
      if (cnt_q != NW'(K)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_COLLECT;
      S_COLLECT: if (accept && sample_last) state_nxt = S_EMIT;
      S_EMIT:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  assign sample_ready = (state == S_COLLECT);
  assign valid_sort   = (state == S_EMIT);
  assign busy         = (state != S_IDLE);
  assign n_valid      = cnt_q;

endmodule
`default_nettype wire
